// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample widths, I2S framing constants and
// the accumulator-to-DAC scaling helper.
package audio_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int DAC_W          = 24;

  typedef logic signed [DAC_W-1:0] dac_sample_t;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

  // Arithmetic right shift followed by saturation to the DAC range.
  // Callers sign-extend their accumulator to 64 bits before calling.
  function automatic dac_sample_t sat_shift(input logic signed [63:0] acc,
                                            input int unsigned        shift);
    logic signed [63:0] scaled;
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    scaled  = acc >>> shift;
    max_val = (64'sd1 <<< (DAC_W - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (DAC_W - 1));
    if (scaled > max_val) begin
      sat_shift = 24'h7FFFFF;
    end else if (scaled < min_val) begin
      sat_shift = 24'h800000;
    end else begin
      sat_shift = scaled[DAC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock and word-clock generator. Produces a strobe one cycle ahead
// of each SCLK falling edge so the caller can register data alongside it.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       sclk_o,
  output logic       lrclk_o,
  output logic       fall_stb,
  output logic       frame_start,
  output logic [4:0] bit_pos
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_next;
  logic             div_wrap;

  // fall_stb marks the cycle whose closing edge drives SCLK low; bit_pos is
  // the slot position that becomes current on that edge.
  assign div_wrap    = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_stb    = div_wrap && sclk_o;
  assign bit_next    = bit_cnt + 6'd1;
  assign frame_start = fall_stb && (bit_cnt == 6'(I2S_FRAME_BITS - 1));
  assign bit_pos     = bit_next[4:0];

  // Divider, SCLK toggle and bit counter; everything parks at zero while idle.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_o  <= 1'b0;
      lrclk_o <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sclk_o  <= ~sclk_o;
      if (sclk_o) begin
        bit_cnt <= bit_next;
        lrclk_o <= bit_next[5];
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// DAC-side I2S transmitter: scales and saturates the FIR accumulator, holds
// one sample in reserve and serialises it as mono on both I2S slots.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 8,
  parameter int DATA_W  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ACC_W-1:0] sample_i,
  input  logic                    sample_valid,
  output logic                    sclk_o,
  output logic                    lrclk_o,
  output logic                    sdata_o,
  output logic                    overrun,
  output logic                    underrun
);

  tx_state_t         state;
  logic [DATA_W-1:0] conv;
  logic [DATA_W-1:0] pending;
  logic              pending_full;
  logic [DATA_W-1:0] frame_word;
  logic              fall_stb;
  logic              frame_start;
  logic [4:0]        bit_pos;
  logic [4:0]        bit_idx;
  logic              slot_bit;

  assign conv = DATA_W'(sat_shift(64'(sample_i), SHIFT));

  // Position 0 is the I2S one-bit delay; positions past the sample width pad with zeros.
  assign bit_idx  = 5'(DATA_W) - bit_pos;
  assign slot_bit = (bit_pos != 5'd0 && bit_pos <= 5'(DATA_W)) ? frame_word[bit_idx] : 1'b0;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .run         (state == TX_RUN),
    .sclk_o      (sclk_o),
    .lrclk_o     (lrclk_o),
    .fall_stb    (fall_stb),
    .frame_start (frame_start),
    .bit_pos     (bit_pos)
  );

  // Start-up, one-deep buffer, frame hand-over and serial data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TX_IDLE;
      pending      <= '0;
      pending_full <= 1'b0;
      frame_word   <= '0;
      sdata_o      <= 1'b0;
      overrun      <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      case (state)
        TX_IDLE: begin
          sdata_o <= 1'b0;
          if (sample_valid) begin
            state      <= TX_RUN;
            frame_word <= conv;
          end
        end
        TX_RUN: begin
          if (frame_start) begin
            if (pending_full) begin
              frame_word <= pending;
            end else begin
              underrun <= 1'b1;
            end
          end
          if (sample_valid) begin
            pending      <= conv;
            pending_full <= 1'b1;
            if (pending_full && !frame_start) begin
              overrun <= 1'b1;
            end
          end else if (frame_start) begin
            pending_full <= 1'b0;
          end
          if (fall_stb) begin
            sdata_o <= slot_bit;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a frame-level model predicts which word
// each I2S frame carries and when the buffer flags pulse; a receiver decodes
// the serial stream and checks it against the prediction.
module tb_i2s_dac_tx;

  localparam int CLK_DIV = 2;
  localparam int ACC_W   = 32;
  localparam int SHIFT   = 4;
  localparam int DATA_W  = 24;
  localparam int FRAME   = 64 * 2 * CLK_DIV;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic signed [ACC_W-1:0] sample_i = '0;
  logic                    sample_valid = 1'b0;
  logic                    sclk_o;
  logic                    lrclk_o;
  logic                    sdata_o;
  logic                    overrun;
  logic                    underrun;

  int tests_run    = 0;
  int tests_failed = 0;

  // model state
  longint            cyc = 0;
  longint            e0 = 0;
  int                gen = 0;
  bit                m_run = 0;
  bit                pend = 0;
  logic [DATA_W-1:0] pend_val = '0;
  logic [DATA_W-1:0] cur = '0;
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_ovr = 0;
  bit                exp_und = 0;
  int                slots_seen = 0;

  i2s_dac_tx #(
    .CLK_DIV (CLK_DIV),
    .ACC_W   (ACC_W),
    .SHIFT   (SHIFT),
    .DATA_W  (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (sample_i),
    .sample_valid (sample_valid),
    .sclk_o       (sclk_o),
    .lrclk_o      (lrclk_o),
    .sdata_o      (sdata_o),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Scale by 2^-SHIFT (rounding toward minus infinity) and clip to the DAC range.
  function automatic logic [DATA_W-1:0] ref_convert(input logic [ACC_W-1:0] raw);
    longint v;
    longint lim_hi;
    longint lim_lo;
    v      = longint'($signed(raw));
    v      = v >>> SHIFT;
    lim_hi = (longint'(1) << (DATA_W - 1)) - 1;
    lim_lo = -(longint'(1) << (DATA_W - 1));
    if (v > lim_hi) v = lim_hi;
    else if (v < lim_lo) v = lim_lo;
    return v[DATA_W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [ACC_W-1:0] v);
    @(negedge clk);
    sample_i     = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Drive a sample so it is sampled on the clock edge that follows the current negedge.
  task automatic applyStimulusNow(input logic [ACC_W-1:0] v);
    sample_i     = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic waitPhase(input int ph);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (m_run && ((cyc - e0) % FRAME) == longint'(ph)) hit = 1;
    end
    if (!hit) checkOutput("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetAndCheck();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_outputs", {27'd0, sclk_o, lrclk_o, sdata_o, overrun, underrun}, 32'd0);
    reset = 1'b0;
  endtask

  // Frame-level reference: frame k starts FRAME cycles after frame k-1, counted
  // from the edge that accepted the first sample.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      exp_ovr = 0;
      exp_und = 0;
      if (reset) begin
        m_run = 0;
        pend  = 0;
        exp_q.delete();
        gen++;
      end else if (!m_run) begin
        if (sample_valid) begin
          m_run = 1;
          e0    = cyc;
          cur   = ref_convert(sample_i);
          exp_q.push_back(cur);
        end
      end else begin
        bit boundary;
        boundary = ((cyc - e0) % FRAME) == 0;
        if (boundary) begin
          if (pend) begin
            cur  = pend_val;
            pend = 0;
          end else begin
            exp_und = 1;
          end
          exp_q.push_back(cur);
        end
        if (sample_valid) begin
          if (pend && !boundary) exp_ovr = 1;
          pend     = 1;
          pend_val = ref_convert(sample_i);
        end
      end
    end
  end

  // Receiver: samples SDATA on SCLK rising edges and rebuilds each slot word.
  initial begin
    int                seen_gen;
    bit                started;
    bit                prev_sclk;
    bit                prev_lr;
    bit                exp_lr;
    bit                pad_ok;
    int                pos;
    logic [DATA_W-1:0] word;
    seen_gen  = -1;
    started   = 0;
    prev_sclk = 0;
    prev_lr   = 0;
    exp_lr    = 0;
    pad_ok    = 1;
    pos       = 0;
    word      = '0;
    forever begin
      @(negedge clk);
      if (exp_ovr || overrun === 1'b1) checkOutput("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      if (exp_und || underrun === 1'b1) checkOutput("underrun", {31'd0, underrun}, {31'd0, exp_und});
      if (seen_gen != gen) begin
        seen_gen  = gen;
        started   = 0;
        prev_sclk = 0;
      end
      if (sclk_o === 1'b1 && !prev_sclk) begin
        if (!started) begin
          started = 1;
          pos     = 0;
          prev_lr = lrclk_o;
          exp_lr  = 0;
          word    = '0;
          pad_ok  = 1;
        end else if (lrclk_o !== prev_lr) begin
          checkOutput("slot_length", pos, 31);
          pos     = 0;
          prev_lr = lrclk_o;
          word    = '0;
          pad_ok  = 1;
        end else begin
          pos++;
        end
        if (pos == 0 || pos > DATA_W) begin
          if (sdata_o !== 1'b0) pad_ok = 0;
        end else begin
          word = {word[DATA_W-2:0], sdata_o};
        end
        if (pos == 31) begin
          slots_seen++;
          if (exp_q.size() == 0) begin
            checkOutput("slot_queue_empty", {8'd0, word}, 32'hFFFF_FFFF);
          end else begin
            checkOutput(prev_lr ? "right_slot" : "left_slot",
                        {6'd0, pad_ok, prev_lr, word},
                        {6'd0, 1'b1, exp_lr, exp_q[0]});
            if (prev_lr) void'(exp_q.pop_front());
          end
          exp_lr = ~exp_lr;
        end
      end
      prev_sclk = (sclk_o === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    int idle_hi;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {27'd0, sclk_o, lrclk_o, sdata_o, overrun, underrun}, 32'd0);
    reset = 1'b0;

    // first sample, then starve the buffer for a few frames
    applyStimulus(32'h0123_4560);
    repeat (3 * FRAME) @(negedge clk);

    // two samples in one frame: the first is lost
    waitPhase(20);
    applyStimulusNow(32'h0000_1000);
    repeat (10) @(negedge clk);
    applyStimulus(32'h0000_2000);
    repeat (FRAME) @(negedge clk);

    // saturation at both rails
    waitPhase(30);
    applyStimulusNow(32'h7FFF_FFFF);
    waitPhase(30);
    applyStimulusNow(32'h8000_0000);
    repeat (2 * FRAME) @(negedge clk);

    // sample arriving on the exact frame-wrap edge while another is pending
    waitPhase(50);
    applyStimulusNow(32'h0000_5550);
    waitPhase(FRAME - 1);
    applyStimulusNow(32'h0000_AAA0);
    repeat (2 * FRAME) @(negedge clk);

    // random traffic
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, FRAME)) @(negedge clk);
      applyStimulus($urandom());
    end
    repeat (2 * FRAME) @(negedge clk);

    // reset in the middle of the right slot, then confirm the clock stays parked
    waitPhase(FRAME / 2 + 40);
    resetAndCheck();
    idle_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sclk_o !== 1'b0) idle_hi++;
    end
    checkOutput("idle_sclk_high_cycles", idle_hi, 0);

    // restart after reset
    applyStimulus(32'h0765_4320);
    repeat (2 * FRAME + 8) @(negedge clk);

    checkOutput("slots_seen_enough", {31'd0, slots_seen >= 30}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
